motor_bridge_driver: RTL
========================

MOTOR_BRIDGE_DRIVER -- requirements
Module: motor_bridge_driver

Interface
REQ-001 Parameter DEAD_CYCLES, default 2, dead-time length in clk cycles; legal range 1..15.
REQ-002 clk  input  1  single system clock; all flops rise-edge triggered.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  bridge enable; 0 forces all gates off.
REQ-005 fault_in  input  1  external overcurrent flag, active-high.
REQ-006 lpwm  input  1  left-motor PWM command from the PWM stage.
REQ-007 rpwm  input  1  right-motor PWM command from the PWM stage.
REQ-008 l_hi, l_lo  output  1 each  left half-bridge high-side and low-side gate drives.
REQ-009 r_hi, r_lo  output  1 each  right half-bridge high-side and low-side gate drives.
REQ-010 fault  output  1  latched fault status.

Function
REQ-011 lpwm and rpwm SHALL each be registered once (pwm_q) before use; there is no combinational path from any input to any output.
REQ-012 Each leg SHALL run an independent FSM with states IDLE, LOW, DT_RISE, HIGH and DT_FALL.
REQ-013 Gate outputs SHALL be flop-driven:
- hi=1 only in HIGH.
- lo=1 only in LOW.
- Both 0 in IDLE, DT_RISE and DT_FALL.
REQ-014 Each leg SHALL contain a 4-bit dead-time counter, loaded with DEAD_CYCLES-1 on entry to DT_RISE or DT_FALL; the leg leaves that state when the count is 0, otherwise it decrements.
REQ-015 Each leg SHALL therefore stay exactly DEAD_CYCLES cycles in DT_RISE or DT_FALL when uninterrupted.
REQ-016 IDLE SHALL go to DT_FALL when en=1 and fault=0, so the low side never closes without a preceding dead time.
REQ-017 LOW SHALL go to DT_RISE when pwm_q=1.
REQ-018 HIGH SHALL go to DT_FALL when pwm_q=0.
REQ-019 DT_RISE SHALL go to HIGH on count expiry with pwm_q=1, and abort to LOW when pwm_q=0 (high side was never on).
REQ-020 DT_FALL SHALL go to LOW on count expiry with pwm_q=0, and return to HIGH when pwm_q=1 (low side was never on).
REQ-021 en=0 or fault=1 SHALL force any state to IDLE on the next edge; this has priority over every other transition.
REQ-022 Latency: a pwm edge present before edge k gives pwm_q at edge k, and the active gate turns off at edge k+1.
REQ-023 The opposite gate SHALL turn on at edge k+1+DEAD_CYCLES.
REQ-024 fault SHALL set on the edge after fault_in=1 is sampled, and stay set until rst, regardless of en and fault_in.
REQ-025 hi and lo of the same leg SHALL never both be 1 in any cycle, under any input sequence.
REQ-026 A pwm pulse shorter than DEAD_CYCLES SHALL never assert the opposite gate; it produces only a dead-time gap and a return to the original state.
REQ-027 Simultaneous en falling and a pwm edge in the same cycle SHALL resolve to IDLE.

Reset
REQ-028 rst=1 at a clock edge SHALL set both legs to IDLE, counters to 0, pwm_q to 0 and fault to 0, giving all gates 0 after that edge.
REQ-029 A mid-operation rst SHALL override all inputs, including fault_in in the same cycle.
REQ-030 After rst deasserts with en=1, each leg SHALL pass through DT_FALL before lo asserts.

Structure
REQ-031 A shared package SHALL hold the leg state enum (IDLE, LOW, DT_RISE, HIGH, DT_FALL) and the counter width constant (4).
REQ-032 One sub-module, bridge_leg, SHALL implement the register, FSM and counter for one leg; the top SHALL instantiate it twice and hold the fault latch.

Verification
REQ-033 Bench SHALL use DEAD_CYCLES=2 and cover these directed scenarios:
- Reset, en=1, lpwm=0: l_lo=1 at the 3rd edge after rst release; l_hi stays 0.
- lpwm 0->1 held: l_lo falls at edge k+1; l_hi rises at edge k+3; both 0 for exactly 2 cycles.
- One-cycle lpwm high pulse while in LOW: l_lo drops for 1 cycle and returns; l_hi never asserts.
- fault_in pulsed for 1 cycle while HIGH: all four gates 0 on the next edge; fault=1 and persists after en toggles, until rst.
- Random lpwm/rpwm/en for 100k cycles: assertions hold for hi&lo==0 per leg and for minimum dead time >= 2 cycles on every gate transfer.
- rst asserted while in DT_RISE: gates 0, fault=0 and state IDLE after one edge.

Source files
------------

// File: rtl/motor_bridge_driver_pkg.sv
// Shared types and constants for the motor H-bridge gate driver.
package motor_bridge_driver_pkg;

    // Width of the per-leg dead-time counter (covers DEAD_CYCLES up to 15).
    localparam int CNT_W = 4;

    // Per-leg switching state.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOW     = 3'd1,
        DT_RISE = 3'd2,
        HIGH    = 3'd3,
        DT_FALL = 3'd4
    } leg_state_e;

    // Counter preload so that a dead-time state lasts exactly dead_cycles clocks.
    function automatic logic [CNT_W-1:0] dead_load(input int dead_cycles);
        return CNT_W'(dead_cycles - 1);
    endfunction

endpackage

// File: rtl/motor_bridge_driver_bridge_leg.sv
// One half-bridge leg: registers its PWM command, sequences the two gates
// through dead-time states, and drives hi/lo straight from flops.
module bridge_leg
    import motor_bridge_driver_pkg::*;
#(
    parameter int DEAD_CYCLES = 2
)
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_stop,
    input  logic       i_pwm,
    output logic       o_hi,
    output logic       o_lo,
    output leg_state_e o_state
);

    localparam logic [CNT_W-1:0] LOAD = dead_load(DEAD_CYCLES);

    logic             r_pwm_q;
    leg_state_e       r_state;
    leg_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_hi;
    logic             r_lo;
    logic             w_hi_nxt;
    logic             w_lo_nxt;

    // State register: PWM sample, FSM state, dead-time counter and gate flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pwm_q <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
        end else begin
            r_pwm_q <= i_pwm;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Next-state and counter logic; a stop request beats every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                // Always pass through a dead time before the low side closes.
                IDLE: begin
                    w_state_nxt = DT_FALL;
                    w_cnt_nxt   = LOAD;
                end
                LOW: begin
                    if (r_pwm_q) begin
                        w_state_nxt = DT_RISE;
                        w_cnt_nxt   = LOAD;
                    end
                end
                HIGH: begin
                    if (!r_pwm_q) begin
                        w_state_nxt = DT_FALL;
                        w_cnt_nxt   = LOAD;
                    end
                end
                // Abort back to LOW if the command drops: the high side never opened.
                DT_RISE: begin
                    if (!r_pwm_q) begin
                        w_state_nxt = LOW;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = HIGH;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                // Return to HIGH if the command comes back: the low side never closed.
                DT_FALL: begin
                    if (r_pwm_q) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = LOW;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Gate decode from the next state, so the gate flops track the state flop.
    always_comb begin
        w_hi_nxt = (w_state_nxt == HIGH);
        w_lo_nxt = (w_state_nxt == LOW);
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_state = r_state;

endmodule

// File: rtl/motor_bridge_driver.sv
// Dual half-bridge gate driver: two dead-time protected legs plus a sticky
// overcurrent latch that shuts both legs down until reset.
module motor_bridge_driver
    import motor_bridge_driver_pkg::*;
#(
    parameter int DEAD_CYCLES = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       fault_in,
    input  logic       lpwm,
    input  logic       rpwm,
    output logic       l_hi,
    output logic       l_lo,
    output logic       r_hi,
    output logic       r_lo,
    output logic       fault,
    output leg_state_e o_dbg_l_state,
    output leg_state_e o_dbg_r_state
);

    logic r_fault;
    logic w_stop;

    // Fault latch: sets on a sampled fault_in, clears only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (fault_in) begin
            r_fault <= 1'b1;
        end
    end

    // The raw flag is included so the gates open on the same edge the latch sets.
    assign w_stop = ~en | fault_in | r_fault;
    assign fault  = r_fault;

    bridge_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_left (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_stop  (w_stop),
        .i_pwm   (lpwm),
        .o_hi    (l_hi),
        .o_lo    (l_lo),
        .o_state (o_dbg_l_state)
    );

    bridge_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_right (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_stop  (w_stop),
        .i_pwm   (rpwm),
        .o_hi    (r_hi),
        .o_lo    (r_lo),
        .o_state (o_dbg_r_state)
    );

endmodule
